// File: rtl/key_load_ctrl.sv
// Serial key-delivery controller for a locked netlist: shifts in a key and a check word,
// verifies the parity-folded check, and only then drives the XOR/MUX key inputs.
module key_load_ctrl #(
  parameter int NUM_XOR    = 10,
  parameter int NUM_MUX    = 1,
  parameter int MUX_WAYS   = 4,
  parameter int CHK_W      = 8,
  parameter int MAX_FAULTS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        load_abort,
  input  logic                        key_in,
  input  logic                        key_in_valid,
  output logic                        key_in_ready,
  output logic [NUM_XOR-1:0]          xor_key,
  output logic [NUM_MUX*MUX_WAYS-1:0] mux_key,
  output logic                        key_armed,
  output logic                        key_fault,
  output logic                        locked_out,
  output logic [3:0]                  fault_cnt
);

  localparam int KEY_W  = NUM_XOR + NUM_MUX * MUX_WAYS;
  localparam int MAX_L  = (KEY_W > CHK_W) ? KEY_W : CHK_W;
  localparam int CNT_W  = $clog2(MAX_L + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_KEY, SHIFT_CHK, ARMED, FAULT, LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   active_q, active_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         fault_cnt_q, fault_cnt_d;
  logic               key_fault_q, key_fault_d;

  logic               beat;
  logic [KEY_W-1:0]   key_wr;
  logic [KEY_W-1:0]   shadow_wr;
  logic [CHK_W-1:0]   chk_full;
  logic [CHK_W-1:0]   chk_exp;
  logic [KEY_W-1:0]   chk_mask [CHK_W];
  logic [3:0]         fault_inc;

  // Check bit i is the parity of every key bit whose index folds onto i modulo CHK_W.
  for (genvar gi = 0; gi < CHK_W; gi++) begin : g_chk
    for (genvar gj = 0; gj < KEY_W; gj++) begin : g_mask
      assign chk_mask[gi][gj] = ((gj % CHK_W) == gi);
    end
    assign chk_exp[gi] = ^(shadow_q & chk_mask[gi]);
  end

  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_wr
    assign key_wr[gi] = (cnt_q == CNT_W'(gi));
  end

  assign key_in_ready = (state_q == SHIFT_KEY) || (state_q == SHIFT_CHK);
  assign beat         = key_in_valid && key_in_ready;
  assign shadow_wr    = (shadow_q & ~key_wr) | (key_wr & {KEY_W{key_in}});
  assign chk_full     = {key_in, chk_q[CHK_W-1:1]};
  assign fault_inc    = (fault_cnt_q == 4'hF) ? 4'hF : fault_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    fault_cnt_d = fault_cnt_q;
    key_fault_d = key_fault_q;
    case (state_q)
      IDLE, FAULT, ARMED: begin
        if (load_start) begin
          state_d     = SHIFT_KEY;
          shadow_d    = '0;
          active_d    = '0;
          chk_d       = '0;
          cnt_d       = '0;
          key_fault_d = 1'b0;
        end
      end
      SHIFT_KEY, SHIFT_CHK: begin
        if (load_abort) begin
          state_d  = IDLE;
          shadow_d = '0;
          chk_d    = '0;
          cnt_d    = '0;
        end else if (load_start) begin
          state_d  = SHIFT_KEY;
          shadow_d = '0;
          chk_d    = '0;
          cnt_d    = '0;
        end else if (beat) begin
          if (state_q == SHIFT_KEY) begin
            shadow_d = shadow_wr;
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              state_d = SHIFT_CHK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            chk_d = chk_full;
            if (cnt_q == CNT_W'(CHK_W - 1)) begin
              cnt_d = '0;
              // Verdict is taken on the edge that accepts the final check bit.
              if (chk_full == chk_exp) begin
                state_d  = ARMED;
                active_d = shadow_q;
              end else begin
                fault_cnt_d = fault_inc;
                key_fault_d = 1'b1;
                state_d     = (fault_inc >= 4'(MAX_FAULTS)) ? LOCKOUT : FAULT;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      LOCKOUT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      fault_cnt_q <= '0;
      key_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      fault_cnt_q <= fault_cnt_d;
      key_fault_q <= key_fault_d;
    end
  end

  assign key_armed  = (state_q == ARMED);
  assign locked_out = (state_q == LOCKOUT);
  assign key_fault  = key_fault_q;
  assign fault_cnt  = fault_cnt_q;
  assign xor_key    = key_armed ? active_q[NUM_XOR-1:0] : '0;
  assign mux_key    = key_armed ? active_q[KEY_W-1:NUM_XOR] : '0;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Randomized bench for key_load_ctrl with a behavioural model of load outcome and fault counting.
module tb_key_load_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       load_abort = 1'b0;
  logic       key_in = 1'b0;
  logic       key_in_valid = 1'b0;
  logic       key_in_ready;
  logic [9:0] xor_key;
  logic [3:0] mux_key;
  logic       key_armed;
  logic       key_fault;
  logic       locked_out;
  logic [3:0] fault_cnt;

  int checks = 0;
  int failures = 0;
  int m_faults = 0;

  always #5 clk = ~clk;

  key_load_ctrl #(
    .NUM_XOR(10), .NUM_MUX(1), .MUX_WAYS(4), .CHK_W(8), .MAX_FAULTS(3)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .key_in(key_in), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .xor_key(xor_key), .mux_key(mux_key), .key_armed(key_armed),
    .key_fault(key_fault), .locked_out(locked_out), .fault_cnt(fault_cnt)
  );

  // Check word: bit i collects the parity of key bits j with j mod 8 == i.
  function automatic logic [7:0] calc_chk(input logic [13:0] k);
    logic [7:0] c = '0;
    for (int j = 0; j < 14; j++) c[j % 8] = c[j % 8] ^ k[j];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int gap_pct, output int beats);
    int i = 0;
    int budget = 0;
    beats = 0;
    while (i < n && budget < 2000) begin
      key_in = w[i];
      key_in_valid = ($urandom_range(99) >= gap_pct);
      if (key_in_valid && key_in_ready) begin
        i++;
        beats++;
      end
      tick();
      budget++;
    end
    key_in_valid = 1'b0;
    checks++;
    if (i !== n) begin
      failures++;
      $display("FAIL send_bits_timeout accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_faults = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({key_in_ready, key_armed, key_fault, locked_out, xor_key, mux_key, fault_cnt} !== '0) begin
      failures++;
      $display("FAIL %s rdy=%b armed=%b fault=%b lock=%b xor=%h mux=%h cnt=%0d required all 0",
               name, key_in_ready, key_armed, key_fault, locked_out, xor_key, mux_key, fault_cnt);
    end
  endtask

  // One complete load from start pulse to verdict, checked against the model.
  task automatic do_load(input string name, input logic [13:0] k, input logic [7:0] c, input int gap_pct);
    int b1, b2;
    logic ok;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (key_in_ready !== 1'b1 || key_armed !== 1'b0 || xor_key !== 10'h0 || key_fault !== 1'b0) begin
      failures++;
      $display("FAIL %s_start rdy=%b armed=%b xor=%h fault=%b required rdy=1 armed=0 xor=0 fault=0",
               name, key_in_ready, key_armed, xor_key, key_fault);
    end
    send_bits({18'b0, k}, 14, gap_pct, b1);
    checks++;
    if (key_armed !== 1'b0) begin
      failures++;
      $display("FAIL %s_midload armed=%b required 0", name, key_armed);
    end
    send_bits({24'b0, c}, 8, gap_pct, b2);
    ok = (c == calc_chk(k));
    if (!ok) m_faults = (m_faults < 15) ? m_faults + 1 : 15;
    checks++;
    if (b1 + b2 != 22) begin
      failures++;
      $display("FAIL %s_beats got=%0d required=22", name, b1 + b2);
    end
    checks++;
    if (key_armed !== ok || key_fault !== !ok || locked_out !== (m_faults >= 3) ||
        fault_cnt !== 4'(m_faults) || key_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_verdict armed=%b fault=%b lock=%b cnt=%0d rdy=%b required armed=%b fault=%b lock=%b cnt=%0d rdy=0",
               name, key_armed, key_fault, locked_out, fault_cnt, key_in_ready,
               ok, !ok, (m_faults >= 3), m_faults);
    end
    checks++;
    if (xor_key !== (ok ? k[9:0] : 10'h0) || mux_key !== (ok ? k[13:10] : 4'h0)) begin
      failures++;
      $display("FAIL %s_keys xor=%h mux=%h required xor=%h mux=%h",
               name, xor_key, mux_key, ok ? k[9:0] : 10'h0, ok ? k[13:10] : 4'h0);
    end
    $display("load %s key=%h chk=%h ok=%b beats=%0d faults=%0d", name, k, c, ok, b1 + b2, m_faults);
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_good_load();
    do_load("good", 14'h2A5C, 8'h76, 0);
    checks++;
    if (xor_key !== 10'h25C || mux_key !== 4'hA) begin
      failures++;
      $display("FAIL good_literal xor=%h mux=%h required xor=25c mux=a", xor_key, mux_key);
    end
  endtask

  task automatic test_bad_chk();
    do_load("bad", 14'h2A5C, 8'h77, 0);
    do_load("reload", 14'h2A5C, 8'h76, 0);
  endtask

  task automatic test_lockout();
    logic [13:0] k;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      k = 14'($urandom);
      do_load("lock_bad", k, calc_chk(k) ^ 8'($urandom_range(1, 255)), 20);
    end
    load_start = 1'b1;
    key_in_valid = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    key_in_valid = 1'b0;
    checks++;
    if (key_in_ready !== 1'b0 || locked_out !== 1'b1 || fault_cnt !== 4'd3 ||
        xor_key !== 10'h0 || mux_key !== 4'h0 || key_armed !== 1'b0) begin
      failures++;
      $display("FAIL lockout_start rdy=%b lock=%b cnt=%0d xor=%h mux=%h armed=%b required 0 1 3 0 0 0",
               key_in_ready, locked_out, fault_cnt, xor_key, mux_key, key_armed);
    end
  endtask

  task automatic test_gaps();
    logic [13:0] k;
    do_reset();
    do_load("gaps", 14'h2A5C, 8'h76, 40);
    for (int n = 0; n < 4; n++) begin
      k = 14'($urandom);
      do_load("rand_gaps", k, calc_chk(k), $urandom_range(0, 60));
    end
  endtask

  task automatic test_abort();
    int b;
    logic [13:0] k;
    do_reset();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_bits(32'($urandom), 7, 0, b);
    load_abort = 1'b1;
    load_start = 1'b1;
    tick();
    load_abort = 1'b0;
    load_start = 1'b0;
    check_idle_outputs("abort");
    // Restart mid-key: do_load's own start pulse lands while still shifting.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_bits(32'($urandom), 5, 0, b);
    k = 14'($urandom);
    do_load("after_abort", k, calc_chk(k), 0);
  endtask

  task automatic test_rst_mid();
    int b;
    logic [13:0] k;
    do_reset();
    k = 14'($urandom);
    do_load("pre_fault", k, ~calc_chk(k), 0);
    do_load("pre_arm", k, calc_chk(k), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_faults = 0;
    check_idle_outputs("rst_armed");
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_bits({18'b0, k}, 14, 0, b);
    send_bits(32'($urandom), 3, 0, b);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_chk");
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_chk();
    test_lockout();
    test_gaps();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
